// File: rtl/dma_pkg.sv
// Shared types for the 8237-side DMA I/O peripheral.
// Channel FSM states and transfer direction encodings.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    XFER,
    DONE
  } periph_state_e;

  localparam logic DIR_TX = 1'b0;
  localparam logic DIR_RX = 1'b1;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO with occupancy level and head output.
// Push when full and pop when empty are silently dropped.
module dma_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == FULL_LVL);
  assign empty   = (level == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      level <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop)  rp <= rp + 1'b1;
      level <= level
             + (AW+1)'(do_push)
             - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

endmodule

// File: rtl/dma_io_peripheral.sv
// Responder end of an 8237 DREQ/DACK channel: strobe-driven
// FIFO data path to a local stream port, with EOP handling.
module dma_io_peripheral
  import dma_pkg::*;
#(
  parameter  int DEPTH            = 8,
  parameter  bit DACK_ACTIVE_HIGH = 1'b1,
  localparam int AW               = $clog2(DEPTH)
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic        DREQ,
  input  logic        DACK,
  input  logic        IOR_N,
  input  logic        IOW_N,
  inout  wire  [7:0]  DB,
  inout  wire         EOP_N,
  input  logic        start,
  input  logic        dir,
  input  logic [15:0] xfer_len,
  input  logic        tx_valid,
  input  logic [7:0]  tx_data,
  output logic        tx_ready,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  input  logic        rx_ready,
  output logic        busy,
  output logic        done,
  output logic        underrun,
  output logic        overrun
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  periph_state_e state, state_nx;

  logic        ack, rd, wr, strb;
  logic        strb_d, rd_d, wr_d;
  logic        cmpl, abort, eop_drv;
  logic        accept, last;
  logic        dir_q, und_q, ovr_q;
  logic        dreq_q, zdone_q;
  logic [15:0] remaining;
  logic [7:0]  wr_data, db_out;
  logic        dma_pop, dma_push;
  logic        f_push, f_pop;
  logic        f_full, f_empty;
  logic [7:0]  f_din, f_head;
  logic [AW:0] f_level;

  assign ack    = (DACK == DACK_ACTIVE_HIGH);
  assign rd     = ack & ~IOR_N;
  assign wr     = ack & ~IOW_N;
  assign strb   = rd | wr;
  assign busy   = (state == ARMED)
                | (state == XFER);
  assign last   = (remaining == 16'd1);
  assign accept = (state == IDLE) & start;
  assign cmpl   = (state == XFER)
                & strb_d & ~strb;

  // Our own EOP drive reads back on the pin; mask it.
  assign eop_drv = busy & strb & last;
  assign abort   = ~EOP_N & ~eop_drv;

  assign dma_pop  = cmpl & rd_d
                  & (dir_q == DIR_TX) & ~f_empty;
  assign dma_push = cmpl & wr_d
                  & (dir_q == DIR_RX) & ~f_full;

  assign tx_ready = (dir_q == DIR_TX) & ~f_full;
  assign rx_valid = (dir_q == DIR_RX) & ~f_empty;
  assign rx_data  = f_head;

  assign f_push = (tx_valid & tx_ready) | dma_push;
  assign f_din  = dma_push ? wr_data : tx_data;
  assign f_pop  = (rx_ready & rx_valid) | dma_pop;

  assign db_out = ((dir_q == DIR_TX) & ~f_empty)
                ? f_head : 8'h00;
  assign DB     = (busy & rd) ? db_out : 8'hzz;
  assign EOP_N  = eop_drv ? 1'b0 : 1'bz;

  assign done     = (state == DONE) | zdone_q;
  assign DREQ     = dreq_q;
  assign underrun = und_q;
  assign overrun  = ovr_q;

  dma_sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RESET_N),
    .push  (f_push),
    .din   (f_din),
    .pop   (f_pop),
    .full  (f_full),
    .empty (f_empty),
    .level (f_level),
    .head  (f_head)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start && xfer_len != 16'd0)
          state_nx = ARMED;
      end
      ARMED: begin
        if (abort)     state_nx = DONE;
        else if (strb) state_nx = XFER;
      end
      XFER: begin
        if (cmpl)
          state_nx = last ? DONE : ARMED;
        if (abort) state_nx = DONE;
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      strb_d    <= 1'b0;
      rd_d      <= 1'b0;
      wr_d      <= 1'b0;
      wr_data   <= 8'h00;
      dir_q     <= DIR_TX;
      remaining <= 16'd0;
      und_q     <= 1'b0;
      ovr_q     <= 1'b0;
      dreq_q    <= 1'b0;
      zdone_q   <= 1'b0;
    end else begin
      strb_d  <= strb;
      rd_d    <= rd;
      wr_d    <= wr;
      zdone_q <= accept & (xfer_len == 16'd0);
      if (wr) wr_data <= DB;
      dreq_q <= busy & ((dir_q == DIR_TX)
              ? (f_level != '0)
              : (f_level != FULL_LVL));
      if (accept) begin
        dir_q     <= dir;
        remaining <= xfer_len;
        und_q     <= 1'b0;
        ovr_q     <= 1'b0;
      end else if (cmpl) begin
        remaining <= remaining - 16'd1;
        if (rd_d & ~dma_pop)  und_q <= 1'b1;
        if (wr_d & ~dma_push) ovr_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dma_io_peripheral.sv
// Bench for dma_io_peripheral: queue-based channel model,
// per-cycle output compare, directed and random blocks.
module tb_dma_io_peripheral;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dack, ior_n, iow_n;
  logic        db_en, ext_eop;
  logic [7:0]  db_val;
  wire  [7:0]  DB;
  wire         EOP_N;
  logic        start, dir;
  logic [15:0] xfer_len;
  logic        tx_valid, rx_ready;
  logic [7:0]  tx_data, rx_data;
  logic        DREQ, tx_ready, rx_valid;
  logic        busy, done, underrun, overrun;

  int n_chk  = 0;
  int n_fail = 0;

  assign DB    = db_en ? db_val : 8'hzz;
  assign EOP_N = ext_eop ? 1'b0 : 1'bz;
  pullup (EOP_N);

  always #5 clk = ~clk;

  dma_io_peripheral #(.DEPTH(DEPTH)) dut (
    .CLK(clk), .RESET_N(rst_n), .DREQ(DREQ),
    .DACK(dack), .IOR_N(ior_n), .IOW_N(iow_n),
    .DB(DB), .EOP_N(EOP_N), .start(start),
    .dir(dir), .xfer_len(xfer_len),
    .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .rx_valid(rx_valid),
    .rx_data(rx_data), .rx_ready(rx_ready),
    .busy(busy), .done(done),
    .underrun(underrun), .overrun(overrun)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Behavioural model: a channel is either busy with a
  // countdown, in its one done cycle, or idle.
  logic [7:0] q[$];
  logic       m_dir, m_busy, m_dst, m_zd;
  logic       m_und, m_ovr, m_dreq;
  logic       p_strb, p_rd, p_wr;
  logic [7:0] m_ws;
  int         m_rem;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      q.delete();
      m_dir = 0; m_busy = 0; m_dst = 0; m_zd = 0;
      m_und = 0; m_ovr = 0; m_dreq = 0;
      p_strb = 0; p_rd = 0; p_wr = 0;
      m_ws = 0; m_rem = 0;
    end else begin
      logic rdi, wri, sti, cm, fin, ob;
      logic popl, pushl, popd, pushd, nd;
      int sz;
      rdi = dack & !ior_n;
      wri = dack & !iow_n;
      sti = rdi | wri;
      sz  = q.size();
      ob  = m_busy;
      cm  = ob & p_strb & !sti;
      popl  = rx_ready & m_dir & (sz > 0);
      pushl = tx_valid & !m_dir & (sz < DEPTH);
      popd = 0; pushd = 0; fin = 0;
      nd = ob & (m_dir ? (sz < DEPTH) : (sz > 0));
      m_zd = 0;
      if (ob) begin
        if (cm) begin
          if (p_rd) begin
            if (!m_dir && sz > 0) popd = 1;
            else m_und = 1;
          end
          if (p_wr) begin
            if (m_dir && sz < DEPTH) pushd = 1;
            else m_ovr = 1;
          end
          if (m_rem == 1) fin = 1;
          m_rem = m_rem - 1;
        end
        if (ext_eop) fin = 1;
        if (fin) begin m_busy = 0; m_dst = 1; end
      end else if (m_dst) begin
        m_dst = 0;
      end else if (start) begin
        m_dir = dir; m_rem = int'(xfer_len);
        m_und = 0; m_ovr = 0;
        if (xfer_len != 0) m_busy = 1;
        else m_zd = 1;
      end
      if (popl || popd) void'(q.pop_front());
      if (pushl) q.push_back(tx_data);
      if (pushd) q.push_back(m_ws);
      if (wri) m_ws = db_val;
      m_dreq = nd;
      p_strb = sti; p_rd = rdi; p_wr = wri;
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_dreq", DREQ, 0);
      chk("rst_done", done, 0);
      chk("rst_eop", EOP_N, 1);
      chk("rst_err", {underrun, overrun}, 0);
    end else begin
      logic sn, eexp;
      sn = dack & (!ior_n | !iow_n);
      eexp = !(ext_eop |
               (m_busy & sn & (m_rem == 1)));
      chk("busy", busy, m_busy);
      chk("done", done, m_dst | m_zd);
      chk("dreq", DREQ, m_dreq);
      chk("underrun", underrun, m_und);
      chk("overrun", overrun, m_ovr);
      chk("tx_ready", tx_ready,
          !m_dir && q.size() < DEPTH);
      chk("rx_valid", rx_valid,
          m_dir && q.size() > 0);
      if (m_dir && q.size() > 0)
        chk("rx_data", rx_data, q[0]);
      chk("eop_n", EOP_N, eexp);
      if (m_busy && dack && !ior_n)
        chk("db", DB, (!m_dir && q.size() > 0)
                      ? q[0] : 8'h00);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic do_start(input logic d,
                          input int len);
    start = 1; dir = d; xfer_len = 16'(len);
    tick();
    start = 0;
  endtask

  task automatic push_b(input logic [7:0] b);
    tx_valid = 1; tx_data = b;
    tick();
    tx_valid = 0;
  endtask

  task automatic pop_b(output logic [7:0] b);
    @(negedge clk);
    b = rx_data;
    rx_ready = 1;
    tick();
    rx_ready = 0;
  endtask

  task automatic ior(output logic [7:0] v,
                     output logic e);
    dack = 1; ior_n = 0;
    @(negedge clk);
    v = DB; e = EOP_N;
    tick();
    ior_n = 1; dack = 0;
    tick();
  endtask

  task automatic iow(input logic [7:0] d,
                     output logic e);
    dack = 1; iow_n = 0; db_en = 1; db_val = d;
    @(negedge clk);
    e = EOP_N;
    tick();
    iow_n = 1; dack = 0; db_en = 0;
    tick();
  endtask

  task automatic wait_dreq();
    for (int i = 0; i < 20; i++) begin
      if (DREQ) break;
      tick();
    end
    chk("dreq_wait", DREQ, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, ab[8];
    logic e;
    rst_n = 0; dack = 0; ior_n = 1; iow_n = 1;
    db_en = 0; db_val = 0; ext_eop = 0;
    start = 0; dir = 0; xfer_len = 0;
    tx_valid = 0; tx_data = 0; rx_ready = 0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    tick();
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_rx_valid", rx_valid, 0);

    // TX block of three bytes
    push_b(8'hA5); push_b(8'h5A); push_b(8'hC3);
    do_start(0, 3);
    wait_dreq();
    ior(v, e); chk("tx_b0", v, 8'hA5);
    chk("tx_e0", e, 1);
    ior(v, e); chk("tx_b1", v, 8'h5A);
    chk("tx_e1", e, 1);
    ior(v, e); chk("tx_b2", v, 8'hC3);
    chk("tx_e2", e, 0);
    @(negedge clk); chk("tx_done", done, 1);
    tick();
    @(negedge clk);
    chk("tx_dreq_off", DREQ, 0);
    chk("tx_busy_off", busy, 0);
    tick();

    // RX block of four bytes
    do_start(1, 4);
    wait_dreq();
    for (int i = 1; i <= 4; i++) begin
      iow(8'(i), e);
      chk("rx_eop", e, (i == 4) ? 0 : 1);
    end
    @(negedge clk); chk("rx_done", done, 1);
    tick();
    for (int i = 1; i <= 4; i++) begin
      pop_b(v); chk("rx_pop", v, i);
    end
    chk("rx_busy", busy, 0);

    // External abort after two of eight
    do_start(0, 8);
    for (int i = 0; i < 8; i++) begin
      ab[i] = 8'($urandom);
      push_b(ab[i]);
    end
    wait_dreq();
    ior(v, e); chk("ab_b0", v, ab[0]);
    ior(v, e); chk("ab_b1", v, ab[1]);
    ext_eop = 1;
    tick();
    ext_eop = 0;
    @(negedge clk);
    chk("ab_done", done, 1);
    chk("ab_rem", dut.remaining, 6);
    chk("ab_level", dut.u_fifo.level, 6);
    tick();
    do_start(0, 6);
    for (int i = 2; i < 8; i++) begin
      ior(v, e); chk("ab_rest", v, ab[i]);
      chk("ab_rest_eop", e, (i == 7) ? 0 : 1);
    end
    tick();

    // Underrun then overrun
    do_start(0, 1);
    ior(v, e); chk("ur_db", v, 8'h00);
    chk("ur_eop", e, 0);
    @(negedge clk); chk("ur_flag", underrun, 1);
    tick();
    do_start(1, DEPTH + 1);
    @(negedge clk); chk("ur_clear", underrun, 0);
    tick();
    for (int i = 1; i <= DEPTH + 1; i++)
      iow(8'(i), e);
    @(negedge clk);
    chk("or_flag", overrun, 1);
    chk("or_level", dut.u_fifo.level, DEPTH);
    tick();
    for (int i = 1; i <= DEPTH; i++) begin
      pop_b(v); chk("or_pop", v, i);
    end

    // Zero-length start
    do_start(0, 0);
    @(negedge clk);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    tick();
    @(negedge clk); chk("z_done_off", done, 0);
    tick();

    // Local push and DMA pop on the same edge
    do_start(0, 2);
    for (int i = 0; i < DEPTH - 1; i++)
      push_b(8'h10 + 8'(i));
    dack = 1; ior_n = 0;
    @(negedge clk); chk("sim_db", DB, 8'h10);
    tick();
    ior_n = 1; dack = 0;
    tx_valid = 1; tx_data = 8'hEE;
    tick();
    tx_valid = 0;
    @(negedge clk);
    chk("sim_level", dut.u_fifo.level, DEPTH - 1);
    tick();
    ior(v, e); chk("sim_b1", v, 8'h11);
    chk("sim_e1", e, 0);
    tick();
    do_start(0, DEPTH - 2);
    for (int i = 2; i < DEPTH - 1; i++) begin
      ior(v, e); chk("sim_ord", v, 8'h10 + 8'(i));
    end
    ior(v, e); chk("sim_last", v, 8'hEE);
    tick();

    // Reset in the middle of a strobe
    do_start(0, 1);
    push_b(8'h77);
    dack = 1; ior_n = 0;
    @(negedge clk);
    chk("mr_eop_on", EOP_N, 0);
    chk("mr_db", DB, 8'h77);
    #1 rst_n = 0;
    #1;
    chk("mr_eop_off", EOP_N, 1);
    chk("mr_dreq", DREQ, 0);
    chk("mr_busy", busy, 0);
    start = 1; dir = 0; xfer_len = 5;
    ior_n = 1; dack = 0;
    tick(); tick();
    start = 0;
    chk("mr_start_ign", busy, 0);
    rst_n = 1;
    tick();
    @(negedge clk);
    chk("mr_after", busy, 0);
    chk("mr_fifo", tx_ready, 1);
    tick();

    // Randomized blocks against the model
    for (int b = 0; b < 25; b++) begin
      int it;
      do_start(1'($urandom), $urandom_range(0, 6));
      it = 0;
      while (m_busy && it < 300) begin
        int r;
        r = $urandom_range(0, 9);
        it++;
        if (r <= 2) begin
          push_b(8'($urandom));
        end else if (r == 3) begin
          rx_ready = 1; tick(); rx_ready = 0;
        end else if (r <= 7) begin
          logic k;
          k = m_dir ^ ($urandom_range(0, 7) == 0);
          if (k) iow(8'($urandom), e);
          else   ior(v, e);
        end else if (r == 9 &&
                     $urandom_range(0, 3) == 0) begin
          ext_eop = 1; tick(); ext_eop = 0;
        end else begin
          tick();
        end
      end
      chk("rand_block_end", busy, 0);
      tick(); tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
